top_level_dec: RTL and testbench

RSA decryption engine: computes message = c^d_key mod n by left-to-right square-and-multiply with a bit-serial interleaved modular multiplier. It is the receive-side counterpart of `top_level_enc`, with the same start/done handshake and operand widths. It sits after the ciphertext channel and returns the recovered plaintext.

---
 rtl/top_level_dec_if.sv | 29 ++
 rtl/top_level_dec.sv | 148 ++++++++++++++
 tb/tb_top_level_dec.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/top_level_dec_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : top_level_dec_if
// Purpose  : Request/result bundle for the RSA decryption engine.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface top_level_dec_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d_key;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] message;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output start, c, d_key, n,
        input  message, done, busy, err
    );

    modport slave (
        input  start, c, d_key, n,
        output message, done, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/top_level_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : top_level_dec
// Purpose  : RSA decrypt, message = c^d_key mod n, left-to-right square-and-
//            multiply over a bit-serial interleaved modular multiplier.
//            Optional operand range check: RSA_DEC_RANGE_CHECK_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module top_level_dec #(
    parameter int WIDTH = 128
) (
    input  logic           clk,
    input  logic           reset,
    top_level_dec_if.slave bus
);
    localparam int            IW        = $clog2(WIDTH);
    localparam logic [IW-1:0] c_TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, e_q, e_d, n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d, acc_q, acc_d, msg_q, msg_d;
    logic [IW-1:0]    i_q, i_d, j_q, j_d;
    logic             done_q, done_d, err_q, err_d;

    logic [WIDTH-1:0] w_mcand;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH-1:0] w_red1;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_step;

    // One modmul step: double-and-reduce, then conditional add-and-reduce.
    // R is always the multiplier; the multiplicand is R (square) or c (multiply).
    assign w_mcand = (state_q == S_MUL) ? c_q : r_q;
    assign w_dbl   = {acc_q, 1'b0};
    assign w_red1  = WIDTH'((w_dbl >= {1'b0, n_q}) ? (w_dbl - {1'b0, n_q}) : w_dbl);
    assign w_sum   = {1'b0, w_red1} + {1'b0, w_mcand};
    assign w_step  = r_q[j_q]
                   ? WIDTH'((w_sum >= {1'b0, n_q}) ? (w_sum - {1'b0, n_q}) : w_sum)
                   : w_red1;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        e_d     = e_q;
        n_d     = n_q;
        r_d     = r_q;
        acc_d   = acc_q;
        msg_d   = msg_q;
        i_d     = i_q;
        j_d     = j_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    c_d     = bus.c;
                    e_d     = bus.d_key;
                    n_d     = bus.n;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                r_d     = WIDTH'(1);
                acc_d   = '0;
                i_d     = c_TOP_IDX;
                j_d     = c_TOP_IDX;
                state_d = S_SQR;
`ifdef RSA_DEC_RANGE_CHECK_EN
                if ((n_q < WIDTH'(2)) || (c_q >= n_q)) begin
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
`endif
            end
            S_SQR, S_MUL: begin
                acc_d = w_step;
                j_d   = j_q - IW'(1);
                if (j_q == '0) begin
                    r_d   = w_step;
                    acc_d = '0;
                    j_d   = c_TOP_IDX;
                    // The square/multiply decision and exponent advance share this cycle.
                    if ((state_q == S_SQR) && e_q[i_q]) begin
                        state_d = S_MUL;
                    end else if (i_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = S_SQR;
                    end
                end
            end
            S_FIN: begin
                msg_d   = r_q;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            msg_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            e_q     <= e_d;
            n_q     <= n_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            msg_q   <= msg_d;
            i_q     <= i_d;
            j_q     <= j_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.message = msg_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_SQR) ||
                         (state_q == S_MUL)  || (state_q == S_FIN);
    assign bus.err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_top_level_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_top_level_dec
// Purpose  : Self-checking bench for top_level_dec (128-bit and 16-bit builds).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_top_level_dec;
    localparam int WB = 128;
    localparam int WS = 16;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    top_level_dec_if #(.WIDTH(WB)) bus_big ();
    top_level_dec_if #(.WIDTH(WS)) bus_sm ();

    top_level_dec #(.WIDTH(WB)) u_big (.clk(clk), .reset(reset), .bus(bus_big));
    top_level_dec #(.WIDTH(WS)) u_sm  (.clk(clk), .reset(reset), .bus(bus_sm));

    // Right-to-left modular exponentiation on wide integers.
    function automatic logic [127:0] ref_modexp(input logic [127:0] b, input logic [127:0] e,
                                                input logic [127:0] m);
        logic [255:0] r, x, mm;
        mm = {128'd0, m};
        r  = 256'd1;
        x  = {128'd0, b} % mm;
        for (int k = 0; k < 128; k++) begin
            if (e[k]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[127:0];
    endfunction

    // Leaves the caller at the falling edge just after the accepting edge E0.
    task automatic start_big(input logic [127:0] c, input logic [127:0] d, input logic [127:0] n);
        @(negedge clk);
        bus_big.c = c; bus_big.d_key = d; bus_big.n = n; bus_big.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_big.start = 1'b0;
    endtask

    task automatic start_sm(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n);
        @(negedge clk);
        bus_sm.c = c; bus_sm.d_key = d; bus_sm.n = n; bus_sm.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_sm.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_big.message !== '0) begin errors++; $display("FAIL rst_msg: got %0h want 0", bus_big.message); end
        checks++; if (bus_big.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus_big.done); end
        checks++; if (bus_big.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus_big.busy); end
        checks++; if (bus_big.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_big.err); end
        checks++; if (bus_sm.done !== 1'b0 || bus_sm.busy !== 1'b0) begin errors++; $display("FAIL rst_small: done %b busy %b want 0 0", bus_sm.done, bus_sm.busy); end
        reset = 1'b1;
    endtask

    task automatic test_basic_and_busy_start();
        logic [127:0] exp_msg;
        int lat;
        exp_msg = ref_modexp(128'd948, 128'd157, 128'd2773);
        lat = 2 + WB * (WB + $countones(128'd157));
        start_big(128'd948, 128'd157, 128'd2773);
        checks++; if (bus_big.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_early: got %b want 1", bus_big.busy); end
        repeat (999) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b want 1", bus_big.busy); end
        // Second request plus changed operands while busy must have no effect.
        bus_big.start = 1'b1; bus_big.c = 128'd5; bus_big.d_key = 128'd3; bus_big.n = 128'd4001;
        @(posedge clk);
        @(negedge clk);
        bus_big.start = 1'b0;
        repeat (lat - 1 - 1000) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b0 || bus_big.busy !== 1'b1) begin errors++; $display("FAIL basic_pre_done: done %b busy %b want 0 1", bus_big.done, bus_big.busy); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b1 || bus_big.busy !== 1'b0) begin errors++; $display("FAIL basic_done: done %b busy %b want 1 0", bus_big.done, bus_big.busy); end
        checks++; if (bus_big.message !== exp_msg) begin errors++; $display("FAIL basic_msg: got %0d want %0d", bus_big.message, exp_msg); end
        checks++; if (bus_big.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus_big.err); end
    endtask

    task automatic test_reset_mid_run();
        start_big(128'd948, 128'd157, 128'd2773);
        checks++; if (bus_big.done !== 1'b0) begin errors++; $display("FAIL mid_done_drop: got %b want 0", bus_big.done); end
        repeat (40) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus_big.message !== '0) begin errors++; $display("FAIL mid_rst_msg: got %0d want 0", bus_big.message); end
        checks++; if (bus_big.done !== 1'b0 || bus_big.busy !== 1'b0 || bus_big.err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: done %b busy %b err %b want 0 0 0", bus_big.done, bus_big.busy, bus_big.err); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_zero_exponent();
        logic [127:0] exp_msg;
        int lat;
        exp_msg = ref_modexp(128'd948, 128'd0, 128'd2773);
        lat = 2 + WB * WB;
        start_big(128'd948, 128'd0, 128'd2773);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b0) begin errors++; $display("FAIL zexp_pre_done: got %b want 0", bus_big.done); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b1) begin errors++; $display("FAIL zexp_done: got %b want 1", bus_big.done); end
        checks++; if (bus_big.message !== exp_msg) begin errors++; $display("FAIL zexp_msg: got %0d want %0d", bus_big.message, exp_msg); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_msg;
        int lat;
        exp_msg = ref_modexp(128'd0, 128'd17, 128'd2773);
        lat = 2 + WB * (WB + $countones(128'd17));
        start_big(128'd0, 128'd17, 128'd2773);
        checks++; if (bus_big.done !== 1'b0 || bus_big.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: done %b busy %b want 0 1", bus_big.done, bus_big.busy); end
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b0) begin errors++; $display("FAIL b2b_pre_done: got %b want 0", bus_big.done); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_big.done !== 1'b1 || bus_big.message !== exp_msg) begin errors++; $display("FAIL b2b_result: done %b msg %0d want 1 %0d", bus_big.done, bus_big.message, exp_msg); end
        repeat (5) @(negedge clk);
        checks++; if (bus_big.done !== 1'b1 || bus_big.message !== exp_msg) begin errors++; $display("FAIL b2b_hold: done %b msg %0d want 1 %0d", bus_big.done, bus_big.message, exp_msg); end
    endtask

    task automatic test_random_small();
        logic [15:0]  c, d, n, exp16;
        logic [127:0] exp_full;
        int lat;
        for (int it = 0; it < 12; it++) begin
            n = 16'(2 + $urandom_range(0, 65533));
            c = 16'($urandom % 32'(n));
            d = 16'($urandom_range(0, 65535));
            case (it)
                0: d = 16'd0;
                1: begin c = 16'd0; if (d == 16'd0) d = 16'd9; end
                2: begin n = 16'd2; c = 16'd1; end
                3: begin n = 16'hFFFF; c = 16'hFFFE; d = 16'hFFFF; end
                default: ;
            endcase
            exp_full = ref_modexp({112'd0, c}, {112'd0, d}, {112'd0, n});
            exp16 = exp_full[15:0];
            lat = 2 + WS * (WS + $countones(d));
            start_sm(c, d, n);
            repeat (lat - 1) @(posedge clk);
            @(negedge clk);
            checks++; if (bus_sm.done !== 1'b0) begin errors++; $display("FAIL rnd%0d_pre_done: got %b want 0", it, bus_sm.done); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus_sm.done !== 1'b1 || bus_sm.message !== exp16) begin errors++; $display("FAIL rnd%0d_result: c=%0d d=%0d n=%0d done %b msg %0d want 1 %0d", it, c, d, n, bus_sm.done, bus_sm.message, exp16); end
        end
    endtask

    task automatic test_range_check();
`ifdef RSA_DEC_RANGE_CHECK_EN
        logic [127:0] exp_full;
        int lat;
        start_sm(16'd2773, 16'd3, 16'd2773);
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_sm.done !== 1'b0) begin errors++; $display("FAIL rng_pre_done: got %b want 0", bus_sm.done); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_sm.done !== 1'b1 || bus_sm.err !== 1'b1 || bus_sm.busy !== 1'b0) begin errors++; $display("FAIL rng_flags: done %b err %b busy %b want 1 1 0", bus_sm.done, bus_sm.err, bus_sm.busy); end
        checks++; if (bus_sm.message !== '0) begin errors++; $display("FAIL rng_msg: got %0d want 0", bus_sm.message); end
        exp_full = ref_modexp(128'd5, 128'd3, 128'd2773);
        lat = 2 + WS * (WS + 2);
        start_sm(16'd5, 16'd3, 16'd2773);
        checks++; if (bus_sm.err !== 1'b0) begin errors++; $display("FAIL rng_err_clear: got %b want 0", bus_sm.err); end
        repeat (lat) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_sm.done !== 1'b1 || bus_sm.message !== exp_full[15:0]) begin errors++; $display("FAIL rng_recover: done %b msg %0d want 1 %0d", bus_sm.done, bus_sm.message, exp_full[15:0]); end
`else
        int lat;
        lat = 2 + WS * (WS + 2);
        start_sm(16'd2773, 16'd3, 16'd2773);
        checks++; if (bus_sm.err !== 1'b0) begin errors++; $display("FAIL rng_off_err_start: got %b want 0", bus_sm.err); end
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_sm.done !== 1'b0) begin errors++; $display("FAIL rng_off_pre_done: got %b want 0", bus_sm.done); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_sm.done !== 1'b1 || bus_sm.err !== 1'b0) begin errors++; $display("FAIL rng_off_done: done %b err %b want 1 0", bus_sm.done, bus_sm.err); end
`endif
    endtask

    initial begin
        bus_big.start = 1'b0; bus_big.c = '0; bus_big.d_key = '0; bus_big.n = '0;
        bus_sm.start  = 1'b0; bus_sm.c  = '0; bus_sm.d_key  = '0; bus_sm.n  = '0;
        test_reset();
        test_basic_and_busy_start();
        test_reset_mid_run();
        test_zero_exponent();
        test_back_to_back();
        test_random_small();
        test_range_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
